// File: rtl/stream_mode_processor_pkg.sv
// Shared definitions for the stream mode processor: mode codes and the luma helper.
package stream_proc_pkg;

   localparam logic [2:0] MODE_PASS   = 3'd0;
   localparam logic [2:0] MODE_GREY   = 3'd1;
   localparam logic [2:0] MODE_THRESH = 3'd2;
   localparam logic [2:0] MODE_INV    = 3'd3;
   localparam logic [2:0] MODE_RED    = 3'd4;
   localparam logic [2:0] MODE_BLACK  = 3'd7;

   // Widest channel the helper supports; callers zero-extend their channels to this.
   localparam int MAX_DATA_W = 16;
   typedef logic [MAX_DATA_W-1:0] chan_t;

   // Y = (R + 2G + B) >> 2, summed two bits wider than the channel, truncated to data_w bits.
   function automatic chan_t grey(input int data_w, input chan_t r, input chan_t g, input chan_t b);
      logic [MAX_DATA_W+1:0] sum;
      chan_t                 mask;
      sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
      mask = chan_t'((32'd1 << data_w) - 32'd1);
      return chan_t'(sum >> 2) & mask;
   endfunction

endpackage

// File: rtl/stream_mode_processor_if.sv
// Pixel stream and resolution-report bundle between capture front end, processor and writer.
interface stream_mode_processor_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 12
);
   logic [DATA_W-1:0] iR, iG, iB;
   logic              iHSync, iVSync, iDataValid, iLineValid;
   logic [2:0]        iMode;
   logic [DATA_W-1:0] iThreshold;

   logic [DATA_W-1:0] oR, oG, oB;
   logic              oHSync, oVSync, oDataValid, oLineValid;
   logic [CNT_W-1:0]  oWidth, oHeight;
   logic              oResValid, oFrameDone, oOverflow;

   modport master (
      output iR, iG, iB, iHSync, iVSync, iDataValid, iLineValid, iMode, iThreshold,
      input  oR, oG, oB, oHSync, oVSync, oDataValid, oLineValid,
      input  oWidth, oHeight, oResValid, oFrameDone, oOverflow
   );

   modport slave (
      input  iR, iG, iB, iHSync, iVSync, iDataValid, iLineValid, iMode, iThreshold,
      output oR, oG, oB, oHSync, oVSync, oDataValid, oLineValid,
      output oWidth, oHeight, oResValid, oFrameDone, oOverflow
   );
endinterface

// File: rtl/stream_mode_processor_res_meter.sv
// Frame resolution meter: saturating width/height counters, sticky saturation, commit on frame end.
module res_meter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_valid,
   input  logic             line_valid,
   output logic             frame_start,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] height,
   output logic             res_valid,
   output logic             frame_done,
   output logic             overflow
);

   logic             dv_prev, lv_prev, armed, sat_flag;
   logic [CNT_W-1:0] width_cnt, height_cnt, line_width;
   logic             dv_fall, lv_fall, line_end, width_sat, height_sat;
   logic [CNT_W-1:0] height_nxt, line_width_nxt;
   logic             sat_nxt;

   assign frame_start = line_valid & ~lv_prev;
   assign dv_fall     = dv_prev & ~data_valid;
   assign lv_fall     = lv_prev & ~line_valid;
   // A line ending on the same sample as the frame still belongs to that frame.
   assign line_end    = dv_fall & (line_valid | lv_prev);

   // Next-value terms shared by the counters and the commit path.
   always_comb begin
      width_sat      = data_valid & line_valid & (&width_cnt);
      height_sat     = line_end & (&height_cnt);
      height_nxt     = (line_end && !(&height_cnt)) ? height_cnt + CNT_W'(1) : height_cnt;
      line_width_nxt = dv_fall ? width_cnt : line_width;
      sat_nxt        = sat_flag | width_sat | height_sat;
   end

   // Counters, edge history and commit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Edge history tracks the real inputs so a frame in flight at release is not seen as a start.
         dv_prev    <= data_valid;
         lv_prev    <= line_valid;
         armed      <= 1'b0;
         sat_flag   <= 1'b0;
         width_cnt  <= '0;
         height_cnt <= '0;
         line_width <= '0;
         width      <= '0;
         height     <= '0;
         res_valid  <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dv_prev    <= data_valid;
         lv_prev    <= line_valid;
         width_cnt  <= data_valid ? ((&width_cnt) ? width_cnt : width_cnt + CNT_W'(1)) : '0;
         line_width <= line_width_nxt;
         height_cnt <= line_valid ? height_nxt : '0;
         sat_flag   <= line_valid ? sat_nxt : 1'b0;
         frame_done <= 1'b0;
         if (frame_start) begin
            armed <= 1'b1;
         end
         if (lv_fall && armed) begin
            width      <= line_width_nxt;
            height     <= height_nxt;
            overflow   <= sat_nxt;
            frame_done <= 1'b1;
            res_valid  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mode_processor.sv
// Per-frame selectable pixel operation through a fixed 2-stage pipeline, plus resolution metering.
module stream_mode_processor
   import stream_proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 12
) (
   input logic iClk,
   input logic iRst,
   stream_mode_processor_if.slave bus
);

   logic              frame_start;
   logic [2:0]        mode_q;
   logic [DATA_W-1:0] s1_r, s1_g, s1_b;
   chan_t             s1_y, s1_thr;
   logic              s1_hs, s1_vs, s1_dv, s1_lv;
   logic [DATA_W-1:0] px_r, px_g, px_b;

   res_meter #(.CNT_W(CNT_W)) u_res_meter (
      .clk         (iClk),
      .rst         (iRst),
      .data_valid  (bus.iDataValid),
      .line_valid  (bus.iLineValid),
      .frame_start (frame_start),
      .width       (bus.oWidth),
      .height      (bus.oHeight),
      .res_valid   (bus.oResValid),
      .frame_done  (bus.oFrameDone),
      .overflow    (bus.oOverflow)
   );

   // Mode is latched only at frame start so a frame is never processed with mixed operations.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         mode_q <= MODE_PASS;
      end else if (frame_start) begin
         mode_q <= bus.iMode;
      end
   end

   // Stage 1: register pixel, syncs, threshold and the luma value.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         s1_r   <= '0;
         s1_g   <= '0;
         s1_b   <= '0;
         s1_y   <= '0;
         s1_thr <= '0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_dv  <= 1'b0;
         s1_lv  <= 1'b0;
      end else begin
         s1_r   <= bus.iR;
         s1_g   <= bus.iG;
         s1_b   <= bus.iB;
         s1_y   <= grey(DATA_W, chan_t'(bus.iR), chan_t'(bus.iG), chan_t'(bus.iB));
         s1_thr <= chan_t'(bus.iThreshold);
         s1_hs  <= bus.iHSync;
         s1_vs  <= bus.iVSync;
         s1_dv  <= bus.iDataValid;
         s1_lv  <= bus.iLineValid;
      end
   end

   // Mode operation on the stage-1 pixel; blanked whenever the pixel is not valid.
   always_comb begin
      px_r = s1_r;
      px_g = s1_g;
      px_b = s1_b;
      case (mode_q)
         MODE_GREY: begin
            px_r = s1_y[DATA_W-1:0];
            px_g = s1_y[DATA_W-1:0];
            px_b = s1_y[DATA_W-1:0];
         end
         MODE_THRESH: begin
            px_r = (s1_y >= s1_thr) ? '1 : '0;
            px_g = (s1_y >= s1_thr) ? '1 : '0;
            px_b = (s1_y >= s1_thr) ? '1 : '0;
         end
         MODE_INV: begin
            px_r = ~s1_r;
            px_g = ~s1_g;
            px_b = ~s1_b;
         end
         MODE_RED: begin
            px_g = '0;
            px_b = '0;
         end
         MODE_BLACK: begin
            px_r = '0;
            px_g = '0;
            px_b = '0;
         end
         default: ;
      endcase
      if (!s1_dv) begin
         px_r = '0;
         px_g = '0;
         px_b = '0;
      end
   end

   // Stage 2: register the result and the syncs so every mode sees the same latency.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         bus.oR         <= '0;
         bus.oG         <= '0;
         bus.oB         <= '0;
         bus.oHSync     <= 1'b0;
         bus.oVSync     <= 1'b0;
         bus.oDataValid <= 1'b0;
         bus.oLineValid <= 1'b0;
      end else begin
         bus.oR         <= px_r;
         bus.oG         <= px_g;
         bus.oB         <= px_b;
         bus.oHSync     <= s1_hs;
         bus.oVSync     <= s1_vs;
         bus.oDataValid <= s1_dv;
         bus.oLineValid <= s1_lv;
      end
   end

endmodule
